// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the accumulator-group sequencer
// Purpose: op encoding, FSM state codes, ALU select bundle and per-op select vectors.
// Ports: none (package).
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_ADC   = 4'h1,
        OP_SUB   = 4'h2,
        OP_SBB   = 4'h3,
        OP_ANA   = 4'h4,
        OP_XRA   = 4'h5,
        OP_ORA   = 4'h6,
        OP_CMP   = 4'h7,
        OP_INR   = 4'h8,
        OP_DCR   = 4'h9,
        OP_A_OUT = 4'hA
    } alu_op_e;

    // State codes kept as plain constants so legacy tools can read them.
    typedef logic [2:0] seq_state_e;
    localparam seq_state_e ST_IDLE  = 3'd0;
    localparam seq_state_e ST_LOAD  = 3'd1;
    localparam seq_state_e ST_OPND  = 3'd2;
    localparam seq_state_e ST_CONST = 3'd3;
    localparam seq_state_e ST_EXEC  = 3'd4;
    localparam seq_state_e ST_DRIVE = 3'd5;

    // carry_in is active-low: 1 means no carry into bit 0.
    typedef struct packed {
        logic op1;
        logic op2;
        logic neg;
        logic ncarry_1;
        logic carry_in;
    } alu_sel_t;

    // ADC/SBB carry_in bits are placeholders; the decoder substitutes the latched carry.
    localparam alu_sel_t SEL_ADD  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam alu_sel_t SEL_ADC  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam alu_sel_t SEL_SUB  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam alu_sel_t SEL_SBB  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam alu_sel_t SEL_ANA  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam alu_sel_t SEL_XRA  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam alu_sel_t SEL_ORA  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam alu_sel_t SEL_CMP  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam alu_sel_t SEL_INC  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam alu_sel_t SEL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= 4'hA;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - per-op ALU selects and sequencing attributes
// Purpose: combinational map of latched op/carry to ALU selects and flow flags.
// Ports: op, cy in; sel, writes_a, writes_cy, needs_operand, tmp_const out.
import alu_seq_pkg::*;

module alu_op_decode (
    input  logic [3:0] op,
    input  logic       cy,
    output alu_sel_t   sel,
    output logic       writes_a,
    output logic       writes_cy,
    output logic       needs_operand,
    output logic       tmp_const
);

    always_comb begin
        sel           = SEL_NONE;
        writes_a      = 1'b1;
        writes_cy     = 1'b1;
        needs_operand = 1'b1;
        tmp_const     = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: sel = SEL_ADD;
            OP_ADC: begin
                sel          = SEL_ADC;
                sel.carry_in = ~cy;
            end
            OP_SUB: sel = SEL_SUB;
            OP_SBB: begin
                sel          = SEL_SBB;
                sel.carry_in = cy;
            end
            OP_ANA: sel = SEL_ANA;
            OP_XRA: sel = SEL_XRA;
            OP_ORA: sel = SEL_ORA;
            OP_CMP: begin
                sel      = SEL_CMP;
                writes_a = 1'b0;
            end
            // INR/DCR are A + const + 1 with const 00 or FE; CY is preserved.
            OP_INR: begin
                sel           = SEL_INC;
                writes_cy     = 1'b0;
                needs_operand = 1'b0;
            end
            OP_DCR: begin
                sel           = SEL_INC;
                writes_cy     = 1'b0;
                needs_operand = 1'b0;
                tmp_const     = 1'b1;
            end
            default: begin
                writes_a      = 1'b0;
                writes_cy     = 1'b0;
                needs_operand = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller for the accumulator/ALU datapath
// Purpose: sequences one accumulator-group op per request, holding ALU selects stable.
// Ports: clk, rst, start, op, carry_flag, operand_valid, abort in;
//        busy, done, aborted, illegal_op, operand_req, flag/ALU selects, datapath strobes out.
import alu_seq_pkg::*;

module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic       carry_flag,
    input  logic       operand_valid,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       illegal_op,
    output logic       operand_req,
    output logic       flag_we,
    output logic       flag_cy_we,
    output logic       alu_carry_in,
    output logic       select_op1,
    output logic       select_op2,
    output logic       select_neg,
    output logic       select_ncarry_1,
    output logic       select_shift_right,
    output logic       shift_right_in,
    output logic       dbus_to_act,
    output logic       a_to_act,
    output logic       alu_to_a,
    output logic       sel_alu_a,
    output logic       alu_a_to_dbus,
    output logic       write_dbus_to_alu_tmp,
    output logic       sel_0_fe,
    output logic       fe_0_to_act
);

    seq_state_e state;
    seq_state_e state_nxt;
    logic [3:0] op_q;
    logic       cy_q;

    alu_sel_t   dec_sel;
    logic       writes_a;
    logic       writes_cy;
    logic       needs_operand;
    logic       tmp_const;

    alu_op_decode u_decode (
        .op            (op_q),
        .cy            (cy_q),
        .sel           (dec_sel),
        .writes_a      (writes_a),
        .writes_cy     (writes_cy),
        .needs_operand (needs_operand),
        .tmp_const     (tmp_const)
    );

    logic accept;
    assign accept = (state == ST_IDLE) && start && is_legal_op(op);

    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nxt = (op == OP_A_OUT) ? ST_DRIVE : ST_LOAD;
                ST_LOAD:  state_nxt = needs_operand ? ST_OPND : ST_CONST;
                ST_OPND:  if (operand_valid) state_nxt = ST_EXEC;
                ST_CONST: state_nxt = ST_EXEC;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath registers capture on the falling edge, so the sequencer does too.
    always_ff @(negedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= 4'h0;
            cy_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= op;
                cy_q <= carry_flag;
            end
        end
    end

    always_comb begin
        busy                  = (state != ST_IDLE);
        illegal_op            = (state == ST_IDLE) && start && !is_legal_op(op);
        aborted               = busy && abort;
        operand_req           = (state == ST_OPND);
        a_to_act              = (state == ST_LOAD);
        sel_0_fe              = (state == ST_CONST);
        fe_0_to_act           = (state == ST_CONST) && tmp_const;
        alu_a_to_dbus         = (state == ST_DRIVE);
        // Abort suppresses every strobe that would commit state in the datapath.
        write_dbus_to_alu_tmp = (state == ST_OPND) && operand_valid && !abort;
        done                  = ((state == ST_EXEC) || (state == ST_DRIVE)) && !abort;
        flag_we               = (state == ST_EXEC) && !abort;
        flag_cy_we            = (state == ST_EXEC) && writes_cy && !abort;
        alu_to_a              = (state == ST_EXEC) && writes_a && !abort;
        select_op1            = busy && dec_sel.op1;
        select_op2            = busy && dec_sel.op2;
        select_neg            = busy && dec_sel.neg;
        select_ncarry_1       = busy && dec_sel.ncarry_1;
        alu_carry_in          = busy && dec_sel.carry_in;
        select_shift_right    = 1'b0;
        shift_right_in        = 1'b0;
        dbus_to_act           = 1'b0;
        sel_alu_a             = 1'b0;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'h0;
    logic       carry_flag = 1'b0;
    logic       operand_valid = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, aborted, illegal_op, operand_req, flag_we, flag_cy_we;
    logic       alu_carry_in, select_op1, select_op2, select_neg, select_ncarry_1;
    logic       select_shift_right, shift_right_in, dbus_to_act, a_to_act, alu_to_a;
    logic       sel_alu_a, alu_a_to_dbus, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act;

    int checks = 0;
    int errors = 0;

    // Small accumulator datapath model driven by the strobes.
    logic [7:0] act_r = 8'h00;
    logic [7:0] tmp_r = 8'h00;
    logic [7:0] a_r = 8'h00;
    logic [7:0] dbus = 8'h00;
    logic [7:0] load_val = 8'h00;
    logic       load_a = 1'b0;
    logic [7:0] alu_res;
    logic [7:0] tmp_eff;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .carry_flag(carry_flag),
        .operand_valid(operand_valid), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .illegal_op(illegal_op), .operand_req(operand_req),
        .flag_we(flag_we), .flag_cy_we(flag_cy_we), .alu_carry_in(alu_carry_in),
        .select_op1(select_op1), .select_op2(select_op2), .select_neg(select_neg),
        .select_ncarry_1(select_ncarry_1), .select_shift_right(select_shift_right),
        .shift_right_in(shift_right_in), .dbus_to_act(dbus_to_act), .a_to_act(a_to_act),
        .alu_to_a(alu_to_a), .sel_alu_a(sel_alu_a), .alu_a_to_dbus(alu_a_to_dbus),
        .write_dbus_to_alu_tmp(write_dbus_to_alu_tmp), .sel_0_fe(sel_0_fe),
        .fe_0_to_act(fe_0_to_act)
    );

    always #5 clk = ~clk;

    logic [21:0] all_outs;
    assign all_outs = {busy, done, aborted, illegal_op, operand_req, flag_we, flag_cy_we,
                       alu_carry_in, select_op1, select_op2, select_neg, select_ncarry_1,
                       select_shift_right, shift_right_in, dbus_to_act, a_to_act, alu_to_a,
                       sel_alu_a, alu_a_to_dbus, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act};

    always_comb begin
        tmp_eff = select_neg ? ~tmp_r : tmp_r;
        if (select_op1 && select_op2)
            alu_res = act_r & tmp_r;
        else if (select_op1 && select_ncarry_1)
            alu_res = act_r ^ tmp_eff;
        else if (!select_op1 && select_ncarry_1)
            alu_res = act_r | tmp_eff;
        else
            alu_res = act_r + tmp_eff + {7'd0, ~alu_carry_in};
    end

    always @(negedge clk) begin
        if (load_a) a_r <= load_val;
        else if (alu_to_a) a_r <= alu_res;
        if (a_to_act) act_r <= a_r;
        if (write_dbus_to_alu_tmp) tmp_r <= dbus;
        else if (sel_0_fe) tmp_r <= fe_0_to_act ? 8'hFE : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic set_a(input logic [7:0] v);
        load_a = 1'b1;
        load_val = v;
        cyc();
        load_a = 1'b0;
    endtask

    int k;
    int done_at;
    int held;

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("reset_outs", {10'd0, all_outs}, 32'd0);

        // ADD, operand valid throughout, A=3C + 0F
        set_a(8'h3C);
        start = 1'b1; op = 4'h0; operand_valid = 1'b1; dbus = 8'h0F;
        #1; cyc();
        start = 1'b0; #1;
        check("add_load", {a_to_act, busy, done}, 3'b110);
        check("add_sel", {select_op1, select_op2, select_neg, select_ncarry_1, alu_carry_in}, 5'b10001);
        cyc(); #1;
        check("add_opnd", {operand_req, write_dbus_to_alu_tmp}, 2'b11);
        cyc();
        start = 1'b1; op = 4'h0; #1;
        check("add_exec", {alu_to_a, flag_we, flag_cy_we, done}, 4'b1111);
        cyc();
        start = 1'b0; operand_valid = 1'b0; #1;
        check("start_in_exec_ignored", busy, 1'b0);
        check("add_result", a_r, 8'h4B);

        // SBB with latched carry 1, carry_flag dropped right after start
        start = 1'b1; op = 4'h3; carry_flag = 1'b1; operand_valid = 1'b1;
        #1; cyc();
        start = 1'b0; carry_flag = 1'b0; #1;
        check("sbb1_load", {select_neg, alu_carry_in}, 2'b11);
        cyc(); #1;
        check("sbb1_opnd", {select_neg, alu_carry_in}, 2'b11);
        cyc(); #1;
        check("sbb1_exec", {select_neg, alu_carry_in, done}, 3'b111);
        cyc();
        start = 1'b1; op = 4'h3; carry_flag = 1'b0;
        #1; cyc();
        start = 1'b0; #1;
        check("sbb0_load", {select_neg, alu_carry_in}, 2'b10);
        cyc(); cyc(); operand_valid = 1'b0;

        // DCR with A=00
        set_a(8'h00);
        start = 1'b1; op = 4'h9;
        #1; cyc();
        start = 1'b0; #1;
        check("dcr_load", a_to_act, 1'b1);
        cyc(); #1;
        check("dcr_const", {sel_0_fe, fe_0_to_act, operand_req}, 3'b110);
        cyc(); #1;
        check("dcr_exec", {done, flag_we, flag_cy_we, alu_to_a}, 4'b1101);
        cyc(); #1;
        check("dcr_result", a_r, 8'hFF);

        // CMP with operand held off for 5 cycles
        start = 1'b1; op = 4'h7;
        #1; cyc();
        start = 1'b0;
        k = 1; done_at = -1; held = 0;
        while (k <= 20 && done_at < 0) begin
            operand_valid = (k >= 7);
            #1;
            if (operand_req && !operand_valid) held++;
            if (done) begin
                done_at = k;
                check("cmp_exec", {alu_to_a, flag_we}, 2'b01);
            end
            cyc();
            k++;
        end
        operand_valid = 1'b0;
        check("cmp_done_cycle", done_at, 32'd8);
        check("cmp_held_cycles", held, 32'd5);

        // Abort in OPND coinciding with operand_valid, then A_OUT
        start = 1'b1; op = 4'h0;
        #1; cyc();
        start = 1'b0; cyc();
        operand_valid = 1'b1; abort = 1'b1; #1;
        check("abort_cycle", {aborted, done, write_dbus_to_alu_tmp}, 3'b100);
        cyc();
        abort = 1'b0; operand_valid = 1'b0; start = 1'b1; op = 4'hA; #1;
        check("abort_idle", busy, 1'b0);
        cyc();
        start = 1'b0; #1;
        check("aout_drive", {busy, done, alu_a_to_dbus, sel_alu_a}, 4'b1110);
        cyc(); #1;
        check("aout_idle", busy, 1'b0);

        // Illegal op
        start = 1'b1; op = 4'hC; #1;
        check("illegal_pulse", {illegal_op, busy}, 2'b10);
        cyc();
        start = 1'b0; #1;
        check("illegal_after", {illegal_op, busy}, 2'b00);

        // Reset while waiting in OPND
        start = 1'b1; op = 4'h1;
        #1; cyc();
        start = 1'b0; cyc(); #1;
        check("rst_pre_opnd", operand_req, 1'b1);
        rst = 1'b1;
        cyc(); #1;
        check("rst_mid_op_outs", {10'd0, all_outs}, 32'd0);
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
